// File: rtl/gsqrt_sched.sv
// gsqrt_sched
//   Schedules jobs from two requesters onto one shared stochastic sqrt
//   datapath. A granted job clears the datapath, runs WARM warm-up cycles
//   whose output is discarded, then counts datapath output ones over a
//   2^W cycle RUN window and returns that count to the requester.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[1:0]        per-requester job request
//   req0_data, req1_data  W-bit unsigned operands
//   req_ready[1:0]        one-cycle accept strobe (combinational, IDLE only)
//   rsp_valid/rsp_ready   result handshake
//   rsp_id, rsp_data      requester index and W+1 bit ones count
//   dp_clr, dp_en         datapath clear pulse and stream-active flag
//   dp_in, dp_rand        datapath input bitstream and comparator random
//   dp_out                datapath output bit (combinational this cycle)
module gsqrt_sched #(
    parameter int BW   = 5,
    parameter int WARM = 4,
    parameter int SEED = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    input  logic [BW:0]   req0_data,
    input  logic [BW:0]   req1_data,
    output logic [1:0]    req_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [BW+1:0] rsp_data,
    output logic          dp_clr,
    output logic          dp_en,
    output logic          dp_in,
    output logic [BW:0]   dp_rand,
    input  logic          dp_out
);
    localparam int W = BW + 1;

    // Feedback tap masks (bit k = state bit k) for maximal-length
    // Fibonacci LFSRs, W = 3..8.
    localparam logic [7:0] TAP8 = (W == 3) ? 8'h06 :
                                  (W == 4) ? 8'h0C :
                                  (W == 5) ? 8'h14 :
                                  (W == 6) ? 8'h30 :
                                  (W == 7) ? 8'h60 : 8'hB8;
    localparam logic [W-1:0] TAPS      = TAP8[W-1:0];
    localparam logic [W-1:0] SEED_W    = W'(SEED);
    localparam logic [7:0]   WARM_LAST = (WARM > 0) ? 8'(WARM - 1) : 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_WARM,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e       state_q, state_d;
    logic         ptr_q, ptr_d;
    logic         id_q, id_d;
    logic [W-1:0] op_q, op_d;
    logic [W-1:0] lfsr_q, lfsr_d;
    logic [7:0]   warm_cnt_q, warm_cnt_d;
    logic [W-1:0] run_cnt_q, run_cnt_d;
    logic [W:0]   ones_q, ones_d;

    logic         grant_idx;
    logic [W-1:0] lfsr_next;
    logic [W-1:0] lfsr_rev;

    // Both valid: pointer holder wins; single valid: that requester wins.
    assign grant_idx = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    assign lfsr_next = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};

    always_comb begin
        lfsr_rev = '0;
        for (int unsigned i = 0; i < W; i++) begin
            lfsr_rev[i] = lfsr_q[W-1-i];
        end
    end

    // State register and job datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            id_q       <= 1'b0;
            op_q       <= '0;
            lfsr_q     <= SEED_W;
            warm_cnt_q <= '0;
            run_cnt_q  <= '0;
            ones_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            op_q       <= op_d;
            lfsr_q     <= lfsr_d;
            warm_cnt_q <= warm_cnt_d;
            run_cnt_q  <= run_cnt_d;
            ones_q     <= ones_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req_valid) state_d = ST_CLR;
            ST_CLR:  state_d = (WARM > 0) ? ST_WARM : ST_RUN;
            ST_WARM: if (warm_cnt_q == WARM_LAST) state_d = ST_RUN;
            ST_RUN:  if (run_cnt_q == '1) state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Job datapath updates
    always_comb begin
        ptr_d      = ptr_q;
        id_d       = id_q;
        op_d       = op_q;
        lfsr_d     = lfsr_q;
        warm_cnt_d = warm_cnt_q;
        run_cnt_d  = run_cnt_q;
        ones_d     = ones_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    id_d  = grant_idx;
                    op_d  = grant_idx ? req1_data : req0_data;
                    ptr_d = ~grant_idx;
                end
            end
            ST_CLR: begin
                lfsr_d     = SEED_W;
                warm_cnt_d = '0;
                run_cnt_d  = '0;
                ones_d     = '0;
            end
            ST_WARM: begin
                lfsr_d     = lfsr_next;
                warm_cnt_d = warm_cnt_q + 8'd1;
            end
            ST_RUN: begin
                lfsr_d    = lfsr_next;
                run_cnt_d = run_cnt_q + W'(1);
                // Exactly 2^W RUN cycles, so the W+1 bit count cannot wrap.
                if (dp_out) ones_d = ones_q + (W+1)'(1);
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        dp_clr    = 1'b0;
        dp_en     = 1'b0;
        case (state_q)
            ST_IDLE: if (|req_valid) req_ready = grant_idx ? 2'b10 : 2'b01;
            ST_CLR:  dp_clr = 1'b1;
            ST_WARM: dp_en = 1'b1;
            ST_RUN:  dp_en = 1'b1;
            ST_DONE: rsp_valid = 1'b1;
            default: ;
        endcase
        dp_in    = dp_en & (op_q > lfsr_q);
        dp_rand  = dp_en ? lfsr_rev : '0;
        rsp_id   = rsp_valid & id_q;
        rsp_data = rsp_valid ? ones_q : '0;
    end

endmodule

// File: tb/tb_gsqrt_sched.sv
// tb_gsqrt_sched
//   Directed bench for gsqrt_sched. u_dut uses WARM=4 with dp_out driven
//   as a constant; u_dut_w0 uses WARM=0 with dp_out from a small stateful
//   stand-in datapath so the ones count depends on the dp_in stream.
module tb_gsqrt_sched;
    localparam int BW = 5;
    localparam int W  = BW + 1;
    localparam logic [W-1:0] SEED = 6'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   req_valid = '0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic [1:0]   req_ready;
    logic         rsp_valid, rsp_id;
    logic         rsp_ready = 1'b0;
    logic [W:0]   rsp_data;
    logic         dp_clr, dp_en, dp_in;
    logic [W-1:0] dp_rand;
    logic         dp_out = 1'b0;

    logic [1:0]   req_valid_b = '0;
    logic [W-1:0] req0_data_b = '0, req1_data_b = '0;
    logic [1:0]   req_ready_b;
    logic         rsp_valid_b, rsp_id_b;
    logic         rsp_ready_b = 1'b0;
    logic [W:0]   rsp_data_b;
    logic         dp_clr_b, dp_en_b, dp_in_b;
    logic [W-1:0] dp_rand_b;
    logic         dp_out_b;
    logic         z_b;

    int n_checks = 0;
    int n_fail = 0;

    gsqrt_sched #(.BW(BW), .WARM(4), .SEED(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req0_data(req0_data), .req1_data(req1_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .dp_clr(dp_clr), .dp_en(dp_en), .dp_in(dp_in),
        .dp_rand(dp_rand), .dp_out(dp_out)
    );

    gsqrt_sched #(.BW(BW), .WARM(0), .SEED(1)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b),
        .req0_data(req0_data_b), .req1_data(req1_data_b), .req_ready(req_ready_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b),
        .rsp_data(rsp_data_b), .dp_clr(dp_clr_b), .dp_en(dp_en_b), .dp_in(dp_in_b),
        .dp_rand(dp_rand_b), .dp_out(dp_out_b)
    );

    // Stand-in datapath: out = in | z, z toggles on in when z is clear.
    assign dp_out_b = dp_in_b | z_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        z_b <= 1'b0;
        else if (dp_clr_b) z_b <= 1'b0;
        else if (dp_en_b)  z_b <= dp_in_b & ~z_b;
    end

    // x^6 + x^5 + 1, shift left, feedback into bit 0
    function automatic logic [W-1:0] m_next(input logic [W-1:0] s);
        return {s[W-2:0], s[5] ^ s[4]};
    endfunction

    function automatic logic [W-1:0] m_rev(input logic [W-1:0] s);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = s[W-1-i];
        return r;
    endfunction

    function automatic int ref_ones(input logic [W-1:0] op);
        logic [W-1:0] m;
        logic z, din;
        int ones;
        m = SEED; z = 1'b0; ones = 0;
        for (int i = 0; i < 64; i++) begin
            din = (op > m);
            ones += int'(din | z);
            z = din & ~z;
            m = m_next(m);
        end
        return ones;
    endfunction

    // Job runner results
    logic [1:0] r_grant;
    int r_lat, r_en_cnt, r_clr_cnt, r_clr_at, r_in_err, r_rand_err, r_rr_err, r_stall_err;
    logic [W:0] r_data;
    logic r_id, r_post_valid;

    // Presents a request on u_dut, tracks the job, stalls rsp_ready for
    // 'stall' cycles in DONE, then handshakes. Called just after a negedge.
    task automatic run_job(input logic [1:0] rv, input logic hold,
                           input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input int stall);
        logic [W-1:0] m, op;
        int n;
        req_valid = rv; req0_data = d0; req1_data = d1; rsp_ready = 1'b0;
        #1;
        r_grant = req_ready;
        op = r_grant[1] ? d1 : d0;
        r_lat = -1; r_en_cnt = 0; r_clr_cnt = 0; r_clr_at = -1;
        r_in_err = 0; r_rand_err = 0; r_rr_err = 0; r_stall_err = 0;
        r_data = 'x; r_id = 1'bx; r_post_valid = 1'bx;
        m = SEED;
        n = 1;
        while (n <= 300 && r_lat < 0) begin
            @(negedge clk);
            if (!hold) req_valid = '0;
            if (req_ready !== 2'b00) r_rr_err++;
            if (dp_clr === 1'b1) begin r_clr_cnt++; r_clr_at = n; m = SEED; end
            if (dp_en === 1'b1) begin
                r_en_cnt++;
                if (dp_in !== (op > m)) r_in_err++;
                if (dp_rand !== m_rev(m)) r_rand_err++;
                m = m_next(m);
            end
            if (rsp_valid === 1'b1) begin r_lat = n; r_data = rsp_data; r_id = rsp_id; end
            n++;
        end
        if (r_lat >= 0) begin
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_id !== r_id || rsp_data !== r_data) r_stall_err++;
                if (req_ready !== 2'b00) r_rr_err++;
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            r_post_valid = rsp_valid;
        end
        req_valid = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
        n_checks++; if (rsp_data !== 7'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %0d expected 0", rsp_data); end
        n_checks++; if (dp_clr !== 1'b0) begin n_fail++; $display("FAIL reset_dp_clr: got %b expected 0", dp_clr); end
        n_checks++; if (dp_en !== 1'b0) begin n_fail++; $display("FAIL reset_dp_en: got %b expected 0", dp_en); end
        n_checks++; if (dp_in !== 1'b0) begin n_fail++; $display("FAIL reset_dp_in: got %b expected 0", dp_in); end
        n_checks++; if (dp_rand !== 6'd0) begin n_fail++; $display("FAIL reset_dp_rand: got %0d expected 0", dp_rand); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid_b !== 1'b0 || dp_en_b !== 1'b0) begin n_fail++; $display("FAIL reset_w0_idle: got %b%b expected 00", rsp_valid_b, dp_en_b); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        dp_out = 1'b0;
        for (int j = 0; j < 4; j++) begin
            run_job(2'b11, 1'b1, 6'd10, 6'd50, 0);
            n_checks++; if (r_grant !== exp_g[j]) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b expected %b", j, r_grant, exp_g[j]); end
            n_checks++; if (r_id !== exp_g[j][1]) begin n_fail++; $display("FAIL b2b_id[%0d]: got %b expected %b", j, r_id, exp_g[j][1]); end
            n_checks++; if (r_data !== 7'd0) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d expected 0", j, r_data); end
            n_checks++; if (r_rr_err !== 0) begin n_fail++; $display("FAIL b2b_ready_outside_idle[%0d]: got %0d expected 0", j, r_rr_err); end
        end
    endtask

    task automatic test_single();
        dp_out = 1'b1;
        run_job(2'b01, 1'b0, 6'd20, 6'd0, 0);
        n_checks++; if (r_grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", r_grant); end
        n_checks++; if (r_clr_cnt !== 1) begin n_fail++; $display("FAIL single_clr_count: got %0d expected 1", r_clr_cnt); end
        n_checks++; if (r_clr_at !== 1) begin n_fail++; $display("FAIL single_clr_cycle: got %0d expected 1", r_clr_at); end
        n_checks++; if (r_lat !== 70) begin n_fail++; $display("FAIL single_latency: got %0d expected 70", r_lat); end
        n_checks++; if (r_en_cnt !== 68) begin n_fail++; $display("FAIL single_en_cycles: got %0d expected 68", r_en_cnt); end
        n_checks++; if (r_id !== 1'b0) begin n_fail++; $display("FAIL single_id: got %b expected 0", r_id); end
        n_checks++; if (r_data !== 7'd64) begin n_fail++; $display("FAIL single_data: got %0d expected 64", r_data); end
        n_checks++; if (r_in_err !== 0) begin n_fail++; $display("FAIL single_dp_in: got %0d bad cycles expected 0", r_in_err); end
        n_checks++; if (r_rand_err !== 0) begin n_fail++; $display("FAIL single_dp_rand: got %0d bad cycles expected 0", r_rand_err); end
        n_checks++; if (r_post_valid !== 1'b0) begin n_fail++; $display("FAIL single_post_valid: got %b expected 0", r_post_valid); end
    endtask

    task automatic test_dp_in();
        dp_out = 1'b0;
        run_job(2'b10, 1'b0, 6'd0, 6'd0, 0);
        n_checks++; if (r_grant !== 2'b10) begin n_fail++; $display("FAIL dpin0_grant: got %b expected 10", r_grant); end
        n_checks++; if (r_in_err !== 0) begin n_fail++; $display("FAIL dpin0_stream: got %0d bad cycles expected 0", r_in_err); end
        n_checks++; if (r_rand_err !== 0) begin n_fail++; $display("FAIL dpin0_rand: got %0d bad cycles expected 0", r_rand_err); end
        // Pointer is now 0; a lone requester 1 must still win.
        run_job(2'b10, 1'b0, 6'd0, 6'd63, 0);
        n_checks++; if (r_grant !== 2'b10) begin n_fail++; $display("FAIL dpin63_grant: got %b expected 10", r_grant); end
        n_checks++; if (r_in_err !== 0) begin n_fail++; $display("FAIL dpin63_stream: got %0d bad cycles expected 0", r_in_err); end
        n_checks++; if (r_id !== 1'b1) begin n_fail++; $display("FAIL dpin63_id: got %b expected 1", r_id); end
    endtask

    task automatic test_stall();
        dp_out = 1'b1;
        run_job(2'b01, 1'b1, 6'd33, 6'd5, 10);
        n_checks++; if (r_lat !== 70) begin n_fail++; $display("FAIL stall_latency: got %0d expected 70", r_lat); end
        n_checks++; if (r_stall_err !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d bad cycles expected 0", r_stall_err); end
        n_checks++; if (r_rr_err !== 0) begin n_fail++; $display("FAIL stall_no_ready: got %0d bad cycles expected 0", r_rr_err); end
        n_checks++; if (r_data !== 7'd64) begin n_fail++; $display("FAIL stall_data: got %0d expected 64", r_data); end
        n_checks++; if (r_post_valid !== 1'b0) begin n_fail++; $display("FAIL stall_post_valid: got %b expected 0", r_post_valid); end
        // Back in IDLE: a request is offered a grant, then withdrawn pre-edge.
        req_valid = 2'b01;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL stall_idle_after_hs: got %b expected 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_midrun();
        int seen;
        dp_out = 1'b1;
        req_valid = 2'b01; req0_data = 6'd40;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrun_grant: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (30) @(negedge clk);
        n_checks++; if (dp_en !== 1'b1) begin n_fail++; $display("FAIL midrun_in_run: got %b expected 1", dp_en); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({dp_clr, dp_en, dp_in, dp_rand} !== 9'd0) begin n_fail++; $display("FAIL midrun_dp_async: got %b expected 0", {dp_clr, dp_en, dp_in, dp_rand}); end
        n_checks++; if ({req_ready, rsp_valid, rsp_id, rsp_data} !== 11'd0) begin n_fail++; $display("FAIL midrun_rsp_async: got %b expected 0", {req_ready, rsp_valid, rsp_id, rsp_data}); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || dp_en !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrun_abandoned: got %0d active cycles expected 0", seen); end
        req_valid = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrun_ptr_reset: got %b expected 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_warm0();
        int lat, en, exp_ones;
        logic [W:0] data;
        exp_ones = ref_ones(6'd16);
        @(negedge clk);
        req_valid_b = 2'b01; req0_data_b = 6'd16; rsp_ready_b = 1'b0;
        #1;
        n_checks++; if (req_ready_b !== 2'b01) begin n_fail++; $display("FAIL w0_grant: got %b expected 01", req_ready_b); end
        lat = -1; en = 0; data = 'x;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            @(negedge clk);
            req_valid_b = 2'b00;
            if (dp_en_b === 1'b1) en++;
            if (rsp_valid_b === 1'b1) begin lat = n; data = rsp_data_b; end
        end
        n_checks++; if (lat !== 66) begin n_fail++; $display("FAIL w0_latency: got %0d expected 66", lat); end
        n_checks++; if (en !== 64) begin n_fail++; $display("FAIL w0_en_cycles: got %0d expected 64", en); end
        n_checks++; if (data !== (W+1)'(exp_ones)) begin n_fail++; $display("FAIL w0_ones: got %0d expected %0d", data, exp_ones); end
        rsp_ready_b = 1'b1;
        @(negedge clk);
        rsp_ready_b = 1'b0;
        n_checks++; if (rsp_valid_b !== 1'b0) begin n_fail++; $display("FAIL w0_post_valid: got %b expected 0", rsp_valid_b); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_dp_in();
        test_stall();
        test_reset_midrun();
        test_warm0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gsqrt_sched.md
GSQRT_SCHED -- requirements
Module: gsqrt_sched

Interface
REQ-001 SHALL have parameter BW, default 5: datapath precision; operand and random width W = BW+1; legal range 2..7.
REQ-002 SHALL have parameter WARM, default 4: warm-up cycles per job during which datapath output is ignored; legal range 0..255.
REQ-003 SHALL have parameter SEED, default 1: LFSR load value, nonzero, W bits.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  2  per-requester job request.
REQ-007 req0_data, req1_data  input  W each  unsigned operand of requester 0 and 1.
REQ-008 req_ready  output  2  per-requester accept strobe.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  result consumer ready.
REQ-011 rsp_id  output  1  requester index of the result.
REQ-012 rsp_data  output  W+1  count of datapath output ones over the RUN window, range 0..2^W.
REQ-013 dp_clr  output  1  one-cycle synchronous clear to the shared sqrt datapath.
REQ-014 dp_en  output  1  datapath stream active.
REQ-015 dp_in  output  1  input bitstream bit to the datapath.
REQ-016 dp_rand  output  W  random number to the datapath comparator.
REQ-017 dp_out  input  1  datapath output bit, combinational in the current cycle.

Function
REQ-018 FSM states: IDLE, CLR, WARM, RUN, DONE.
REQ-019 IDLE: if any req_valid bit is 1, grant one requester; req_ready[g]=1 combinationally in that cycle only; latch operand and g; next state CLR. req_ready SHALL be 0 in every other state.
REQ-020 Arbitration: round-robin. Priority pointer resets to 0. Both valid -> grant the pointer holder. Single valid -> grant it regardless of pointer. Pointer moves to the non-granted index on each grant.
REQ-021 CLR: dp_clr=1 for exactly one cycle; LFSR loaded with SEED; RUN counter and ones count cleared. Next state WARM if WARM>0, else RUN.
REQ-022 WARM: lasts exactly WARM cycles; dp_en=1; dp_out ignored.
REQ-023 RUN: lasts exactly 2^W cycles; dp_en=1; each cycle, if dp_out=1, ones count +1. Next state DONE.
REQ-024 LFSR: W-bit maximal-length Fibonacci LFSR, advances once per cycle in WARM and RUN, holds otherwise. Polynomials: W=3 x^3+x^2+1; W=4 x^4+x^3+1; W=5 x^5+x^3+1; W=6 x^6+x^5+1; W=7 x^7+x^6+1; W=8 x^8+x^6+x^5+x^4+1.
REQ-025 dp_in = (latched operand > LFSR state) while dp_en=1, else 0.
REQ-026 dp_rand = bit-reversed LFSR state while dp_en=1, else 0.
REQ-027 Ones count SHALL be W+1 bits wide and SHALL NOT wrap; 2^W ones yields rsp_data = 2^W.
REQ-028 DONE: rsp_valid=1 with stable rsp_id and rsp_data until rsp_ready=1; on handshake, next state IDLE.
REQ-029 Latency: accept at cycle t -> dp_clr at t+1 -> rsp_valid first high at t+2+WARM+2^W.
REQ-030 A new request SHALL be acceptable no earlier than the cycle after the rsp handshake; req_valid changes outside IDLE SHALL be ignored.
REQ-031 dp_clr, dp_en, dp_in and dp_rand SHALL be 0 in IDLE and DONE.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state IDLE, pointer 0, LFSR SEED, counters 0, all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_data, dp_*).
REQ-033 Reset during CLR, WARM, RUN or DONE SHALL abandon the job with no response; after release, the pending requester must re-request.

Verification
REQ-034 BW=5, WARM=4, dp_out tied 1, req_valid=01, req0_data=20 -> req_ready=01 one cycle; dp_clr one cycle later; rsp_valid 70 cycles after accept; rsp_id=0; rsp_data=64.
REQ-035 Both req_valid=11 held, rsp_ready=1, dp_out tied 0 -> grants in order 0,1,0,1; each rsp_data=0; rsp_id alternates.
REQ-036 Operand 0 -> dp_in=0 in every WARM/RUN cycle; operand 63 -> dp_in=0 only in cycles where LFSR=63.
REQ-037 rsp_ready held 0 for 10 cycles in DONE -> rsp_valid, rsp_id, rsp_data stable; no req_ready pulse; IDLE one cycle after handshake.
REQ-038 rst_n pulsed low mid-RUN -> all outputs 0 immediately; no rsp_valid; next request granted to requester 0 when both valid.
REQ-039 WARM=0, dp_out driven by a reference GSQRT model, operand 16 -> rsp_data equals the model's ones count over the 64 RUN cycles; dp_en high exactly 64 cycles.
